hex_page_scanner: RTL and testbench
===================================

HEX_PAGE_SCANNER -- requirements
Module: hex_page_scanner

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of debug channels (2..16).
REQ-002 SHALL have parameter CH_WIDTH, default 32: bits per channel (multiple of 4, 4..32).
REQ-003 SHALL have parameter DWELL_CYCLES, default 50000000: clk cycles per page in auto mode (>=2).
REQ-004 SHALL have derived constant SEL_W = clog2(NUM_CH), minimum 1.
REQ-005 SHALL use one clock and an asynchronous active-low reset: clk  in  1  system clock; reset_n  in  1  async active-low reset.
REQ-006 ch_data  in  NUM_CH*CH_WIDTH  packed channels; channel k at bits [k*CH_WIDTH +: CH_WIDTH].
REQ-007 manual_sel  in  SEL_W  channel selected in manual mode.
REQ-008 auto_mode  in  1  1 = auto-rotate pages, 0 = manual.
REQ-009 step  in  1  single-cycle pulse; advances page in auto mode.
REQ-010 freeze  in  1  level; 1 = hold displayed value and page.
REQ-011 blank_lz  in  1  1 = blank leading zero digits.
REQ-012 page  out  SEL_W  channel currently displayed.
REQ-013 frozen  out  1  high while display is held.
REQ-014 digits  out  32  registered nibbles; digit i at [4i+3:4i].
REQ-015 digit_en  out  8  per-digit enable.
REQ-016 hex  out  56  7-segment patterns, digit i at [7i+6:7i].

Function
REQ-017 SHALL implement states MANUAL, AUTO, HOLD; MANUAL when auto_mode=0 and freeze=0; AUTO when auto_mode=1 and freeze=0; HOLD whenever freeze=1, from either state.
REQ-018 In MANUAL, page SHALL equal manual_sel registered one cycle later, clamped to NUM_CH-1 when manual_sel >= NUM_CH.
REQ-019 On MANUAL->AUTO, page SHALL keep its current value and the dwell counter SHALL load 0.
REQ-020 In AUTO, dwell counter SHALL count 0..DWELL_CYCLES-1; on terminal count page SHALL advance by 1 and counter reload 0.
REQ-021 Page advance SHALL wrap NUM_CH-1 -> 0.
REQ-022 step in AUTO SHALL advance page and reload counter 0; step coincident with terminal count SHALL advance exactly one page.
REQ-023 step in MANUAL or HOLD SHALL be ignored.
REQ-024 Entering HOLD SHALL capture the channel value displayed in that cycle into a snapshot register; page and dwell counter SHALL hold while in HOLD.
REQ-025 Leaving HOLD SHALL resume the state selected by auto_mode with counter value retained.
REQ-026 digits SHALL update one cycle after page or ch_data change (registered); in HOLD digits SHALL show the snapshot.
REQ-027 digits above CH_WIDTH/4 SHALL be 0 and their digit_en 0.
REQ-028 With blank_lz=1, digit_en SHALL be 0 for zero digits above the most significant non-zero digit; digit 0 SHALL always be enabled.
REQ-029 With blank_lz=0, digit_en SHALL be 1 for all digits below CH_WIDTH/4.
REQ-030 hex SHALL be the combinational decode of digits/digit_en, all segments off (7'h7F) when disabled.
REQ-031 frozen SHALL be registered, high in HOLD.

Reset
REQ-032 On reset_n low, asynchronously: state MANUAL, page 0, counter 0, snapshot 0, digits 0, digit_en 8'h01, frozen 0.
REQ-033 Reset mid-page or in HOLD SHALL abandon the snapshot; first post-reset display SHALL follow REQ-018/017 after one cycle.

Structure
REQ-034 State encoding and the segment blank constant SHALL reside in shared package hex_pkg.
REQ-035 Per-digit segment decode SHALL reuse the existing hex_driver sub-module, eight instances.

Verification (NUM_CH=4, CH_WIDTH=24, DWELL_CYCLES=8)
REQ-036 Manual select: ch2=24'h00A5F0, manual_sel=2, blank_lz=1 -> page=2, digits=32'h0000A5F0, digit_en=8'h0F after one cycle.
REQ-037 Auto wrap: auto_mode=1 from page 3 -> page=0 after 8 cycles, page=1 after 16.
REQ-038 Step/terminal collision: step on counter=7 -> page advances by exactly 1, counter=0.
REQ-039 Freeze: freeze=1 with ch1=24'h123456, then ch1 changes to 24'h000000 -> digits stay 32'h00123456, frozen=1, page static for 20 cycles.
REQ-040 Clamp/width: manual_sel=5 is not representable; drive manual_sel=3 with NUM_CH=3 build -> page=2; digit 6/7 enables always 0.
REQ-041 Reset mid-HOLD: reset_n low 1 cycle during HOLD -> all outputs at REQ-032 values immediately, frozen=0.

Source files
------------

// File: rtl/hex_pkg.sv
// Shared definitions for the hex page scanner: display-mode encoding and the
// active-low seven-segment blank pattern.
package hex_pkg;

  typedef enum logic [1:0] {
    StManual = 2'd0,
    StAuto   = 2'd1,
    StHold   = 2'd2
  } scan_state_e;

  // Segments are active-low, bit order gfedcba.
  localparam logic [6:0] SegBlank = 7'h7F;

endpackage

// File: rtl/hex_driver.sv
// One seven-segment digit: active-low gfedcba decode of a nibble, blanked when
// the digit is disabled.
module hex_driver
  import hex_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       en_i,
  output logic [6:0] seg_o
);

  logic [6:0] seg;

  always_comb begin
    seg = SegBlank;
    case (nibble_i)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = SegBlank;
    endcase
  end

  assign seg_o = en_i ? seg : SegBlank;

endmodule

// File: rtl/hex_page_scanner.sv
// Pages one of NUM_CH debug channels onto an eight-digit hex display, either
// manually selected or auto-rotating, with a freeze that holds a snapshot.
module hex_page_scanner
  import hex_pkg::*;
#(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned CH_WIDTH     = 32,
  parameter int unsigned DWELL_CYCLES = 50000000,
  localparam int unsigned SEL_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_CH*CH_WIDTH-1:0] ch_data,
  input  logic [SEL_W-1:0]           manual_sel,
  input  logic                       auto_mode,
  input  logic                       step,
  input  logic                       freeze,
  input  logic                       blank_lz,
  output logic [SEL_W-1:0]           page,
  output logic                       frozen,
  output logic [31:0]                digits,
  output logic [7:0]                 digit_en,
  output logic [55:0]                hex
);

  localparam int unsigned CNT_W = $clog2(DWELL_CYCLES);
  localparam int ND = int'(CH_WIDTH / 4);
  localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(NUM_CH - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYCLES - 1);

  scan_state_e         state_q, state_d;
  logic [SEL_W-1:0]    page_q, page_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CH_WIDTH-1:0] snap_q, snap_d;
  logic [31:0]         digits_q, digits_d;
  logic [7:0]          digit_en_q, digit_en_d;
  logic                frozen_q, frozen_d;
  logic [CH_WIDTH-1:0] live, shown;
  logic                seen;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StManual;
      page_q     <= '0;
      cnt_q      <= '0;
      snap_q     <= '0;
      digits_q   <= '0;
      digit_en_q <= 8'h01;
      frozen_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      page_q     <= page_d;
      cnt_q      <= cnt_d;
      snap_q     <= snap_d;
      digits_q   <= digits_d;
      digit_en_q <= digit_en_d;
      frozen_q   <= frozen_d;
    end
  end

  always_comb begin
    state_d = freeze ? StHold : (auto_mode ? StAuto : StManual);
    page_d  = page_q;
    cnt_d   = cnt_q;
    case (state_d)
      StManual: begin
        page_d = (manual_sel > LAST_CH) ? LAST_CH : manual_sel;
        cnt_d  = '0;
      end
      StAuto: begin
        // A step landing on terminal count still advances only one page.
        if (step || cnt_q == CNT_LAST) begin
          page_d = (page_q == LAST_CH) ? '0 : page_q + SEL_W'(1);
          cnt_d  = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Mux follows the next page so digits and page change on the same edge.
  always_comb begin
    live = '0;
    for (int k = 0; k < int'(NUM_CH); k++) begin
      if (page_d == SEL_W'(k)) live = ch_data[k*CH_WIDTH +: CH_WIDTH];
    end
  end

  always_comb begin
    snap_d   = (state_d == StHold && state_q != StHold) ? live : snap_q;
    shown    = (state_d == StHold) ? snap_d : live;
    digits_d = 32'(shown);
    frozen_d = (state_d == StHold);
  end

  always_comb begin
    digit_en_d = '0;
    seen       = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (i < ND) begin
        if (digits_d[4*i +: 4] != 4'h0) seen = 1'b1;
        digit_en_d[i] = !blank_lz || seen || (i == 0);
      end
    end
  end

  for (genvar g = 0; g < 8; g++) begin : g_dig
    hex_driver u_hex_driver (
      .nibble_i (digits_q[4*g +: 4]),
      .en_i     (digit_en_q[g]),
      .seg_o    (hex[7*g +: 7])
    );
  end

  assign page     = page_q;
  assign frozen   = frozen_q;
  assign digits   = digits_q;
  assign digit_en = digit_en_q;

endmodule

// File: tb/tb_hex_page_scanner.sv
// Directed plus randomized checks of hex_page_scanner against a cycle-level
// behavioural model of the paging, freeze and blanking rules.
module tb_hex_page_scanner;

  localparam int NCH = 4;
  localparam int CW  = 24;
  localparam int DW  = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [95:0]   ch_data;
  logic [1:0]    manual_sel, manual_sel3;
  logic          auto_mode, step, freeze, blank_lz;
  logic [1:0]    page, page3;
  logic          frozen, frozen3;
  logic [31:0]   digits, digits3;
  logic [7:0]    digit_en, digit_en3;
  logic [55:0]   hex, hex3;

  hex_page_scanner #(.NUM_CH(NCH), .CH_WIDTH(CW), .DWELL_CYCLES(DW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ch_data    (ch_data),
    .manual_sel (manual_sel),
    .auto_mode  (auto_mode),
    .step       (step),
    .freeze     (freeze),
    .blank_lz   (blank_lz),
    .page       (page),
    .frozen     (frozen),
    .digits     (digits),
    .digit_en   (digit_en),
    .hex        (hex)
  );

  hex_page_scanner #(.NUM_CH(3), .CH_WIDTH(CW), .DWELL_CYCLES(DW)) dut3 (
    .clk        (clk),
    .reset_n    (reset_n),
    .ch_data    (ch_data[71:0]),
    .manual_sel (manual_sel3),
    .auto_mode  (auto_mode),
    .step       (step),
    .freeze     (freeze),
    .blank_lz   (blank_lz),
    .page       (page3),
    .frozen     (frozen3),
    .digits     (digits3),
    .digit_en   (digit_en3),
    .hex        (hex3)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  int          m_page, m_cnt, m_prev;
  logic [23:0] m_snap;
  logic [31:0] m_digits;
  logic [7:0]  m_en;
  logic        m_frozen;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  function automatic logic [7:0] exp_en(input logic [31:0] v, input logic blz);
    logic [7:0] e = '0;
    for (int i = 0; i < CW / 4; i++) e[i] = !blz || (i == 0) || ((v >> (4 * i)) != 0);
    return e;
  endfunction

  function automatic logic [55:0] exp_hex(input logic [31:0] v, input logic [7:0] en);
    logic [55:0] h;
    for (int i = 0; i < 8; i++) h[7*i +: 7] = en[i] ? seg_tab[v[4*i +: 4]] : 7'h7F;
    return h;
  endfunction

  function automatic logic [23:0] chv(input int k);
    return ch_data[k*CW +: CW];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("page", 64'(page), 64'(m_page));
    check("frozen", 64'(frozen), 64'(m_frozen));
    check("digits", 64'(digits), 64'(m_digits));
    check("digit_en", 64'(digit_en), 64'(m_en));
    check("hex", 64'(hex), 64'(exp_hex(m_digits, m_en)));
    check("n3_en_hi", 64'(digit_en3[7:6]), 64'(0));
  endtask

  task automatic model_reset();
    m_page = 0; m_cnt = 0; m_prev = 0; m_snap = '0;
    m_digits = '0; m_en = 8'h01; m_frozen = 1'b0;
  endtask

  task automatic model_step();
    int mode;
    logic [23:0] shown;
    mode = freeze ? 2 : (auto_mode ? 1 : 0);
    if (mode == 0) begin
      m_page = (int'(manual_sel) >= NCH) ? NCH - 1 : int'(manual_sel);
      m_cnt  = 0;
    end else if (mode == 1) begin
      if (step || m_cnt == DW - 1) begin
        m_page = (m_page + 1) % NCH;
        m_cnt  = 0;
      end else begin
        m_cnt++;
      end
    end
    shown = chv(m_page);
    if (mode == 2) begin
      if (m_prev != 2) m_snap = shown;
      shown = m_snap;
    end
    m_digits = 32'(shown);
    m_en     = exp_en(32'(shown), blank_lz);
    m_frozen = (mode == 2);
    m_prev   = mode;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    int p0;
    reset_n = 1'b0; ch_data = '0; manual_sel = '0; manual_sel3 = '0;
    auto_mode = 1'b0; step = 1'b0; freeze = 1'b0; blank_lz = 1'b0;
    model_reset();
    #12;
    check_all();
    check("rst_en", 64'(digit_en), 64'(8'h01));
    reset_n = 1'b1;

    // Manual select with leading-zero blanking.
    for (int k = 0; k < NCH; k++) ch_data[k*CW +: CW] = 24'($urandom);
    ch_data[2*CW +: CW] = 24'h00A5F0;
    manual_sel = 2'd2; blank_lz = 1'b1;
    tick();
    check("sel_page", 64'(page), 64'(2));
    check("sel_digits", 64'(digits), 64'(32'h0000A5F0));
    check("sel_en", 64'(digit_en), 64'(8'h0F));

    // Auto rotation wraps from the last page.
    manual_sel = 2'd3;
    tick();
    auto_mode = 1'b1;
    repeat (8) tick();
    check("wrap8", 64'(page), 64'(0));
    repeat (8) tick();
    check("wrap16", 64'(page), 64'(1));

    // Step coincident with terminal count.
    for (int n = 0; n < 16 && m_cnt != DW - 1; n++) tick();
    p0 = m_page;
    step = 1'b1;
    tick();
    step = 1'b0;
    check("collide", 64'(page), 64'((p0 + 1) % NCH));
    repeat (7) tick();
    check("collide_hold", 64'(page), 64'((p0 + 1) % NCH));
    tick();
    check("collide_next", 64'(page), 64'((p0 + 2) % NCH));

    // Freeze holds the snapshot while the channel changes underneath.
    auto_mode = 1'b0; manual_sel = 2'd1; blank_lz = 1'b0;
    ch_data[CW +: CW] = 24'h123456;
    tick();
    freeze = 1'b1;
    tick();
    ch_data[CW +: CW] = 24'h000000;
    for (int n = 0; n < 20; n++) begin
      tick();
      check("frz_digits", 64'(digits), 64'(32'h00123456));
      check("frz_page", 64'(page), 64'(1));
      check("frz_flag", 64'(frozen), 64'(1));
    end

    // Asynchronous reset in HOLD.
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    check_all();
    check("rst_frozen", 64'(frozen), 64'(0));
    @(negedge clk);
    reset_n = 1'b1; freeze = 1'b0; manual_sel = 2'd2;
    tick();
    check("post_rst", 64'(page), 64'(2));

    // Clamp on the three-channel build.
    manual_sel3 = 2'd3;
    tick();
    check("clamp3", 64'(page3), 64'(2));

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      for (int k = 0; k < NCH; k++)
        ch_data[k*CW +: CW] = 24'($urandom) >> $urandom_range(0, 24);
      if ($urandom_range(0, 15) == 0) auto_mode = ~auto_mode;
      if ($urandom_range(0, 11) == 0) freeze = ~freeze;
      if ($urandom_range(0, 7) == 0) blank_lz = ~blank_lz;
      step = ($urandom_range(0, 3) == 0);
      manual_sel  = 2'($urandom);
      manual_sel3 = 2'($urandom);
      tick();
    end
    step = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
